// File: rtl/calc_alu_seq.sv
// calc_alu_seq: sequenced ALU with one registered 2*WIDTH-bit result.
// Logic/ADD/SUB finish in one execute cycle; MUL is a WIDTH-step shift-add.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   start    : request strobe, sampled only while idle
//   op       : 000 XOR, 001 AND, 010 OR, 011 ADD, 100 SUB, 101 MUL, else invalid
//   num1     : operand A, captured with start
//   num2     : operand B, captured with start
//   busy     : high in every state except idle
//   done     : one-cycle completion pulse
//   ans      : registered result, held until the next completion
//   carry    : ADD carry-out / SUB borrow, 0 otherwise
//   zero     : completed result is zero
//   err      : completed op code was invalid
module calc_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] ans,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_XOR = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [AW-1:0]    r_ans;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;

    state_t           w_state;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [CW-1:0]    w_cnt;
    logic [AW-1:0]    w_acc;
    logic [AW-1:0]    w_mcand;
    logic [WIDTH-1:0] w_mplier;
    logic [AW-1:0]    w_ans;
    logic             w_carry;
    logic             w_zero;
    logic             w_err;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_dif;
    logic             w_borrow;
    logic [AW-1:0]    w_exec_res;
    logic             w_exec_carry;
    logic             w_exec_err;
    logic [AW-1:0]    w_step_sum;

    // Single-cycle datapath, evaluated from the latched operands.
    always_comb begin
        w_sum        = {1'b0, r_a} + {1'b0, r_b};
        w_dif        = r_a - r_b;
        w_borrow     = (r_a < r_b);
        w_exec_res   = '0;
        w_exec_carry = 1'b0;
        w_exec_err   = 1'b0;
        case (r_op)
            OP_XOR: w_exec_res = AW'(r_a ^ r_b);
            OP_AND: w_exec_res = AW'(r_a & r_b);
            OP_OR:  w_exec_res = AW'(r_a | r_b);
            OP_ADD: begin
                w_exec_res   = AW'(w_sum);
                w_exec_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_exec_res   = AW'(w_dif);
                w_exec_carry = w_borrow;
            end
            default: w_exec_err = 1'b1;
        endcase
    end

    // Multiplicand is pre-shifted each step, so only multiplier bit 0
    // needs testing; the accumulator sum is the product on the last step.
    assign w_step_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_state  = r_state;
        w_a      = r_a;
        w_b      = r_b;
        w_op     = r_op;
        w_cnt    = r_cnt;
        w_acc    = r_acc;
        w_mcand  = r_mcand;
        w_mplier = r_mplier;
        w_ans    = r_ans;
        w_carry  = r_carry;
        w_zero   = r_zero;
        w_err    = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a      = num1;
                    w_b      = num2;
                    w_op     = op;
                    w_cnt    = '0;
                    w_acc    = '0;
                    w_mcand  = AW'(num1);
                    w_mplier = num2;
                    w_state  = (op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                w_ans   = w_exec_res;
                w_carry = w_exec_carry;
                w_err   = w_exec_err;
                w_zero  = (w_exec_res == '0);
                w_state = S_DONE;
            end
            S_MUL: begin
                w_acc    = w_step_sum;
                w_mcand  = r_mcand << 1;
                w_mplier = r_mplier >> 1;
                w_cnt    = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_ans   = w_step_sum;
                    w_carry = 1'b0;
                    w_err   = 1'b0;
                    w_zero  = (w_step_sum == '0);
                    w_state = S_DONE;
                end
            end
            S_DONE: w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_ans    <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_a      <= w_a;
            r_b      <= w_b;
            r_op     <= w_op;
            r_cnt    <= w_cnt;
            r_acc    <= w_acc;
            r_mcand  <= w_mcand;
            r_mplier <= w_mplier;
            r_ans    <= w_ans;
            r_carry  <= w_carry;
            r_zero   <= w_zero;
            r_err    <= w_err;
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign ans   = r_ans;
    assign carry = r_carry;
    assign zero  = r_zero;
    assign err   = r_err;

endmodule

// File: tb/tb_calc_alu_seq.sv
// tb_calc_alu_seq: directed self-checking bench for calc_alu_seq.
// Drives a WIDTH=8 instance through all ops and a WIDTH=4 instance for MUL.
module tb_calc_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  num1;
    logic [7:0]  num2;
    logic        busy;
    logic        done;
    logic [15:0] ans;
    logic        carry;
    logic        zero;
    logic        err;

    logic        reset_n4;
    logic        start4;
    logic [2:0]  op4;
    logic [3:0]  num1_4;
    logic [3:0]  num2_4;
    logic        busy4;
    logic        done4;
    logic [7:0]  ans4;
    logic        carry4;
    logic        zero4;
    logic        err4;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    calc_alu_seq #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .num1    (num1),
        .num2    (num2),
        .busy    (busy),
        .done    (done),
        .ans     (ans),
        .carry   (carry),
        .zero    (zero),
        .err     (err)
    );

    calc_alu_seq #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n4),
        .start   (start4),
        .op      (op4),
        .num1    (num1_4),
        .num2    (num2_4),
        .busy    (busy4),
        .done    (done4),
        .ans     (ans4),
        .carry   (carry4),
        .zero    (zero4),
        .err     (err4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for done (bounded), then one edge back to idle.
    // lat: edges from accept to first done; bcnt: cycles busy was high.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input bit abuse,
                          output int lat, output int bcnt);
        start = 1'b1;
        op    = o;
        num1  = a;
        num2  = b;
        step();
        start = 1'b0;
        op    = 3'b011;
        num1  = ~a;
        num2  = ~b;
        bcnt  = busy ? 1 : 0;
        lat   = 0;
        for (int i = 1; i <= 40; i++) begin
            if (abuse && i == 3) begin
                start = 1'b1;
                op    = 3'b011;
                num1  = 8'h11;
                num2  = 8'h22;
            end else begin
                start = 1'b0;
            end
            step();
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        step();
        if (busy) bcnt++;
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    int lat;
    int bcnt;
    int ndone;
    int dpos[$];

    initial begin
        reset_n  = 1'b0;
        start    = 1'b1;
        op       = 3'b011;
        num1     = 8'h01;
        num2     = 8'h01;
        reset_n4 = 1'b0;
        start4   = 1'b0;
        op4      = 3'b000;
        num1_4   = 4'h0;
        num2_4   = 4'h0;

        // Reset with start asserted: nothing may be latched.
        step();
        step();
        chk("rst_ans", ans, 16'h0000);
        chk("rst_flags", {carry, zero, err, busy, done}, 5'b00000);
        start    = 1'b0;
        reset_n  = 1'b1;
        reset_n4 = 1'b1;
        step();
        chk("rst_idle", {busy, done}, 2'b00);

        run_op(3'b000, 8'hA5, 8'h3C, 1'b0, lat, bcnt);
        chk("xor_ans", ans, 16'h0099);
        chk("xor_lat", lat, 1);
        chk("xor_fl", {carry, zero, err}, 3'b000);
        chk("xor_busy", bcnt, 2);

        run_op(3'b001, 8'hA5, 8'h3C, 1'b0, lat, bcnt);
        chk("and_ans", ans, 16'h0024);
        chk("and_lat", lat, 1);
        chk("and_fl", {carry, zero, err}, 3'b000);

        run_op(3'b010, 8'hA5, 8'h3C, 1'b0, lat, bcnt);
        chk("or_ans", ans, 16'h00BD);
        chk("or_lat", lat, 1);
        chk("or_fl", {carry, zero, err}, 3'b000);

        run_op(3'b000, 8'h5A, 8'h5A, 1'b0, lat, bcnt);
        chk("xor0_ans", ans, 16'h0000);
        chk("xor0_fl", {carry, zero, err}, 3'b010);

        run_op(3'b011, 8'hFF, 8'h01, 1'b0, lat, bcnt);
        chk("add_ans", ans, 16'h0100);
        chk("add_fl", {carry, zero, err}, 3'b100);
        chk("add_lat", lat, 1);

        run_op(3'b100, 8'h05, 8'h07, 1'b0, lat, bcnt);
        chk("sub_ans", ans, 16'h00FE);
        chk("sub_fl", {carry, zero, err}, 3'b100);

        run_op(3'b100, 8'h07, 8'h07, 1'b0, lat, bcnt);
        chk("sub0_ans", ans, 16'h0000);
        chk("sub0_fl", {carry, zero, err}, 3'b010);

        run_op(3'b101, 8'hFF, 8'hFF, 1'b0, lat, bcnt);
        chk("mul_ans", ans, 16'hFE01);
        chk("mul_lat", lat, 8);
        chk("mul_busy", bcnt, 9);
        chk("mul_fl", {carry, zero, err}, 3'b000);

        run_op(3'b101, 8'h00, 8'h37, 1'b0, lat, bcnt);
        chk("mul0_ans", ans, 16'h0000);
        chk("mul0_fl", {carry, zero, err}, 3'b010);

        run_op(3'b101, 8'h0D, 8'h0B, 1'b0, lat, bcnt);
        chk("mul13x11", ans, 16'h008F);

        // ADD strobe during MUL must be ignored.
        run_op(3'b101, 8'hFF, 8'hFF, 1'b1, lat, bcnt);
        chk("abuse_ans", ans, 16'hFE01);
        chk("abuse_lat", lat, 8);
        step();
        chk("abuse_noq", {busy, done}, 2'b00);

        // Start held high: three ADDs, done every 3 cycles.
        start = 1'b1;
        op    = 3'b011;
        num1  = 8'h10;
        num2  = 8'h20;
        ndone = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (done) begin
                ndone++;
                dpos.push_back(i);
            end
        end
        start = 1'b0;
        chk("hold_cnt", ndone, 3);
        if (dpos.size() == 3) begin
            chk("hold_d0", dpos[0], 2);
            chk("hold_d1", dpos[1], 5);
            chk("hold_d2", dpos[2], 8);
        end
        chk("hold_ans", ans, 16'h0030);
        step();
        chk("hold_idle", {busy, done}, 2'b00);

        run_op(3'b110, 8'h12, 8'h34, 1'b0, lat, bcnt);
        chk("inv_ans", ans, 16'h0000);
        chk("inv_fl", {carry, zero, err}, 3'b011);
        chk("inv_lat", lat, 1);

        // Reset during step 4 of MUL: aborted, no done.
        start = 1'b1;
        op    = 3'b101;
        num1  = 8'hFF;
        num2  = 8'hFF;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset_n = 1'b0;
        step();
        chk("abort_st", {busy, done}, 2'b00);
        chk("abort_ans", ans, 16'h0000);
        chk("abort_fl", {carry, zero, err}, 3'b000);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) ndone++;
        end
        chk("abort_quiet", ndone, 0);

        run_op(3'b011, 8'h02, 8'h03, 1'b0, lat, bcnt);
        chk("post_ans", ans, 16'h0005);
        chk("post_fl", {carry, zero, err}, 3'b000);

        // WIDTH=4 multiply.
        start4 = 1'b1;
        op4    = 3'b101;
        num1_4 = 4'hF;
        num2_4 = 4'hF;
        step();
        start4 = 1'b0;
        lat    = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done4) begin
                lat = i;
                break;
            end
        end
        chk("m4_lat", lat, 4);
        chk("m4_ans", ans4, 8'hE1);
        chk("m4_fl", {carry4, zero4, err4}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
